// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, defaults and index helper for the round-robin arbitrated mux
package rr_arb_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int N_DEF     = 4;
   localparam int SEL_W_DEF = $clog2(N_DEF);

   typedef logic [SEL_W_DEF-1:0] sel_t;

   // Output register occupancy: EMPTY holds no word, FULL presents one downstream.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } stage_t;

   // N is a power of two, so dropping the carry gives the modulo-N wrap.
   function automatic sel_t next_idx(sel_t i);
      return i + sel_t'(1);
   endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin grant starting the scan at ptr
module rr_grant
   import rr_arb_pkg::*;
#(
   parameter  int N     = N_DEF,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);

   logic [SEL_W-1:0] idx;

   // Scan from the farthest offset back to ptr so the closest requester wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = ptr;
      idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// rtl/rr_arb_mux_4_1.sv - round-robin arbitrated N:1 mux with a registered output stage
module rr_arb_mux_4_1
   import rr_arb_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int N     = N_DEF,
   localparam int SEL_W = $clog2(N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             in_valid,
   input  logic [N-1:0][WIDTH-1:0]  in_data,
   output logic [N-1:0]             in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_sel
);

   stage_t           state_q;
   stage_t           state_d;
   logic [SEL_W-1:0] ptr;
   logic             gnt_valid;
   logic [SEL_W-1:0] gnt_idx;
   logic             load_en;
   logic             xfer;

   rr_grant #(.N(N)) u_grant (
      .req       (in_valid),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A fresh load wins over a drain, so a simultaneous drain+accept stays FULL.
   always_comb begin
      state_d = state_q;
      if (xfer) begin
         state_d = FULL;
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   // in_ready depends on other channels only through gnt_idx, never on itself.
   always_comb begin
      out_valid         = (state_q == FULL);
      load_en           = !out_valid || out_ready;
      xfer              = load_en && gnt_valid;
      in_ready          = '0;
      in_ready[gnt_idx] = xfer;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_sel  <= '0;
         ptr      <= '0;
      end else if (xfer) begin
         out_data <= in_data[gnt_idx];
         out_sel  <= gnt_idx;
         ptr      <= gnt_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb/tb_rr_arb_mux_4_1.sv - self-checking scoreboard bench for rr_arb_mux_4_1
module tb_rr_arb_mux_4_1;
   import rr_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 4;

   typedef struct packed {
      sel_t         sel;
      logic [W-1:0] data;
   } word_t;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         in_valid;
   logic [N-1:0][W-1:0]  in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [W-1:0]         out_data;
   logic [1:0]           out_sel;

   int           n_checks = 0;
   int           n_fail   = 0;
   word_t        sb[$];
   sel_t         mptr     = '0;
   logic         mvalid   = 1'b0;
   logic [N-1:0] acc      = '0;
   int           wait_cnt[N];

   rr_arb_mux_4_1 #(.WIDTH(W), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      mptr   = '0;
      mvalid = 1'b0;
      acc    = '0;
      sb.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
   endtask

   // Sample on the falling edge, update the scoreboard, then return 1 time unit after the rising edge.
   task automatic cycle();
      logic         mload;
      logic         found;
      int           g;
      logic [N-1:0] exp_rdy;
      word_t        w;
      @(negedge clk);
      mload = !mvalid || out_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(mptr) + k) % N;
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            g     = idx;
         end
      end
      exp_rdy = '0;
      if (mload && found) exp_rdy[g] = 1'b1;
      n_checks++;
      if (in_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
      end
      n_checks++;
      if (out_valid !== mvalid) begin
         n_fail++;
         $display("FAIL out_valid: got %b expected %b", out_valid, mvalid);
      end
      if (mvalid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got word sel=%0d data=%h expected none", out_sel, out_data);
         end else begin
            w = sb[0];
            if (out_sel !== w.sel || out_data !== w.data) begin
               n_fail++;
               $display("FAIL out_word: got sel=%0d data=%h expected sel=%0d data=%h",
                        out_sel, out_data, w.sel, w.data);
            end
            if (out_ready) void'(sb.pop_front());
         end
      end
      acc = '0;
      if (mload && found) begin
         w.sel  = sel_t'(g);
         w.data = in_data[g];
         sb.push_back(w);
         acc[g] = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (i == g || !in_valid[i]) begin
               wait_cnt[i] = 0;
            end else begin
               wait_cnt[i]++;
               n_checks++;
               if (wait_cnt[i] > N - 1) begin
                  n_fail++;
                  $display("FAIL fairness: ch%0d waited %0d transfers, limit %0d", i, wait_cnt[i], N - 1);
               end
            end
         end
         mptr   = next_idx(sel_t'(g));
         mvalid = 1'b1;
      end else if (out_ready) begin
         mvalid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic [1:0] es, input logic [W-1:0] ed);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== es || out_data !== ed) begin
         n_fail++;
         $display("FAIL %s: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                  name, out_valid, out_sel, out_data, es, ed);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
         n_fail++;
         $display("FAIL reset_init: got v=%b data=%h sel=%0d expected 0/0/0", out_valid, out_data, out_sel);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 4'b1111;
      in_data  = {4'h4, 4'h3, 4'h2, 4'h1};
      cycle();
      cycle();
      check_out("pre_reset_word", 2'd0, 4'h1);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got v=%b data=%h sel=%0d expected 0/0/0", out_valid, out_data, out_sel);
      end
      model_reset();
      in_valid = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_all_channels();
      logic [1:0]   es[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [W-1:0] ed[5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL first_grant: got %b expected 0001", in_ready);
      end
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_out("rotation", es[k], ed[k]);
      end
      in_valid = '0;
      cycle();
   endtask

   task automatic test_wrap_skip();
      logic [1:0] es[3] = '{2'd3, 2'd1, 2'd3};
      in_data  = {4'h3, 4'h0, 4'h1, 4'h0};
      in_valid = 4'b0010;
      cycle();
      check_out("ptr_setup", 2'd1, 4'h1);
      in_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_out("wrap_skip", es[k], in_data[es[k]]);
      end
      in_valid = '0;
      cycle();
   endtask

   task automatic test_backpressure();
      out_ready  = 1'b0;
      in_data    = '0;
      in_data[2] = 4'h5;
      in_valid   = 4'b0100;
      cycle();
      check_out("bp_load", 2'd2, 4'h5);
      in_valid   = 4'b0001;
      in_data[0] = 4'h7;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_out("bp_hold", 2'd2, 4'h5);
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready: got %b expected 0000", in_ready);
         end
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL bp_release: got %b expected 0001", in_ready);
      end
      cycle();
      check_out("bp_next", 2'd0, 4'h7);
      in_valid = '0;
   endtask

   task automatic test_idle();
      out_ready = 1'b1;
      in_valid  = '0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_drain: got out_valid=%b expected 0", out_valid);
         end
      end
      in_valid = 4'b1111;
      in_data  = {4'hD, 4'hC, 4'hB, 4'hA};
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL idle_ptr: got %b expected 0010", in_ready);
      end
      cycle();
      check_out("idle_resume", 2'd1, 4'hB);
      in_valid = '0;
      cycle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (acc[i]) in_valid[i] = 1'b0;
            if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
               in_valid[i] = 1'b1;
               in_data[i]  = W'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      in_valid  = '0;
      out_ready = 1'b1;
      repeat (3) cycle();
      n_checks++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL random_drain: got %0d words left, out_valid=%b expected 0 and 0", sb.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_all_channels();
      test_wrap_skip();
      test_backpressure();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
